qspi_shift_engine: RTL and testbench

//  Serial PHY stage downstream of the command sequence generator.
//  - Accepts one segment per handshake: command, address or data; up to 32 bits; 1- or 4-lane; TX or RX.
//  - Drives SCK/CS_n/IO to the flash in SPI mode 0 and returns received bits right-aligned.
//  - Consecutive segments stay inside a single CS_n frame until a segment flagged last completes.

---
 rtl/qspi_shift_engine.sv | 195 +++++++++++++++++++
 tb/tb_qspi_shift_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_shift_engine.sv
// Serial PHY for a QSPI flash: shifts one command/address/data segment at a time
// in SPI mode 0, keeping CS_n asserted across segments until one is flagged last.
module qspi_shift_engine #(
  parameter int CLK_DIV        = 2,
  parameter int CS_IDLE_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  num_bits_i,
  input  logic        rx_i,
  input  logic        quad_i,
  input  logic        last_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] rx_data_o,
  output logic        sck_o,
  output logic        cs_n_o,
  output logic [3:0]  io_o,
  output logic [3:0]  io_oe_o,
  input  logic [3:0]  io_i
);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, CS_HOLD, CS_IDLE} state_e;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] IDLE_LAST = 16'(CS_IDLE_CYCLES - 1);

  state_e      state_q;
  logic [15:0] tick_q;
  logic [5:0]  sckLeft_q;
  logic [5:0]  nbits_q;
  logic        isRx_q;
  logic        isQuad_q;
  logic        isLast_q;
  logic [31:0] txShift_q;
  logic [31:0] rxShift_q;
  logic        ready_q;
  logic        done_q;
  logic [31:0] rxData_q;
  logic        sck_q;
  logic        csN_q;
  logic [3:0]  io_q;
  logic [3:0]  ioOe_q;

  logic [5:0]  nbits_d;
  logic [5:0]  nibbles_d;
  logic [5:0]  sckCnt_d;
  logic [5:0]  padWidth_d;
  logic [31:0] txAligned_d;
  logic [31:0] txRemain_d;
  logic [3:0]  firstIo_d;
  logic [3:0]  ioOe_d;
  logic [3:0]  nextIo_d;
  logic [31:0] rxShift_d;
  logic [31:0] rxMask_d;

  // Segment preparation: the TX word is masked to its bit count and left-justified to
  // the padded width so the first bit/nibble always sits at the top of the shifter.
  always_comb begin
    nbits_d     = (num_bits_i > 6'd32) ? 6'd32 : num_bits_i;
    nibbles_d   = (nbits_d + 6'd3) >> 2;
    sckCnt_d    = quad_i ? nibbles_d : nbits_d;
    padWidth_d  = quad_i ? (nibbles_d << 2) : nbits_d;
    txAligned_d = (data_i & ~(32'hFFFF_FFFF << nbits_d)) << (6'd32 - padWidth_d);
    firstIo_d   = 4'b0000;
    txRemain_d  = 32'h0;
    if (!rx_i) begin
      firstIo_d  = quad_i ? txAligned_d[31:28] : {3'b000, txAligned_d[31]};
      txRemain_d = quad_i ? (txAligned_d << 4) : (txAligned_d << 1);
    end
    if (rx_i) ioOe_d = quad_i ? 4'b0000 : 4'b0001;
    else      ioOe_d = quad_i ? 4'b1111 : 4'b0001;
    nextIo_d  = isQuad_q ? txShift_q[31:28] : {3'b000, txShift_q[31]};
    rxShift_d = isQuad_q ? {rxShift_q[27:0], io_i} : {rxShift_q[30:0], io_i[1]};
    rxMask_d  = ~(32'hFFFF_FFFF << nbits_q);
  end

  // Main sequencer; every pin-facing output is a register so SCK/CS_n/IO are glitch-free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      tick_q    <= 16'd0;
      sckLeft_q <= 6'd0;
      nbits_q   <= 6'd0;
      isRx_q    <= 1'b0;
      isQuad_q  <= 1'b0;
      isLast_q  <= 1'b0;
      txShift_q <= 32'h0;
      rxShift_q <= 32'h0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      rxData_q  <= 32'h0;
      sck_q     <= 1'b0;
      csN_q     <= 1'b1;
      io_q      <= 4'b0000;
      ioOe_q    <= 4'b0000;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_i) begin
            nbits_q   <= nbits_d;
            isRx_q    <= rx_i;
            isQuad_q  <= quad_i;
            isLast_q  <= last_i;
            rxShift_q <= 32'h0;
            tick_q    <= 16'd0;
            if (sckCnt_d == 6'd0) begin
              // Empty segment completes at once and never touches SCK or CS_n.
              done_q <= 1'b1;
              if (rx_i) rxData_q <= 32'h0;
              if (last_i) begin
                ready_q <= 1'b0;
                state_q <= CS_HOLD;
              end
            end else begin
              ready_q   <= 1'b0;
              csN_q     <= 1'b0;
              io_q      <= firstIo_d;
              ioOe_q    <= ioOe_d;
              txShift_q <= txRemain_d;
              sckLeft_q <= sckCnt_d;
              state_q   <= SHIFT_LO;
            end
          end
        end
        SHIFT_LO: begin
          if (tick_q == DIV_LAST) begin
            tick_q    <= 16'd0;
            sck_q     <= 1'b1;
            rxShift_q <= rxShift_d;
            state_q   <= SHIFT_HI;
          end else begin
            tick_q <= tick_q + 16'd1;
          end
        end
        SHIFT_HI: begin
          if (tick_q == DIV_LAST) begin
            tick_q <= 16'd0;
            sck_q  <= 1'b0;
            if (sckLeft_q == 6'd1) begin
              done_q <= 1'b1;
              if (isRx_q) rxData_q <= rxShift_q & rxMask_d;
              if (isLast_q) begin
                state_q <= CS_HOLD;
              end else begin
                ready_q <= 1'b1;
                state_q <= IDLE;
              end
            end else begin
              sckLeft_q <= sckLeft_q - 6'd1;
              io_q      <= nextIo_d;
              txShift_q <= isQuad_q ? (txShift_q << 4) : (txShift_q << 1);
              state_q   <= SHIFT_LO;
            end
          end else begin
            tick_q <= tick_q + 16'd1;
          end
        end
        CS_HOLD: begin
          if (tick_q == DIV_LAST) begin
            tick_q  <= 16'd0;
            csN_q   <= 1'b1;
            io_q    <= 4'b0000;
            ioOe_q  <= 4'b0000;
            state_q <= CS_IDLE;
          end else begin
            tick_q <= tick_q + 16'd1;
          end
        end
        CS_IDLE: begin
          if (tick_q == IDLE_LAST) begin
            tick_q  <= 16'd0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            tick_q <= tick_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o   = ready_q;
  assign done_o    = done_q;
  assign rx_data_o = rxData_q;
  assign sck_o     = sck_q;
  assign cs_n_o    = csN_q;
  assign io_o      = io_q;
  assign io_oe_o   = ioOe_q;

endmodule

// File: tb/tb_qspi_shift_engine.sv
// Directed bench for qspi_shift_engine: a table of segments with hand-computed results
// plus hand-written sequences for held load_i and reset during a shift.
module tb_qspi_shift_engine;

  localparam int CLK_DIV        = 2;
  localparam int CS_IDLE_CYCLES = 4;

  typedef struct {
    logic        rx;
    logic        quad;
    logic [5:0]  nb;
    logic [31:0] data;
    logic        last;
    logic [31:0] rxSrc;
    int          expDone;
    int          expRises;
    logic [31:0] expTx;
    logic [31:0] expRx;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        load_i;
  logic [31:0] data_i;
  logic [5:0]  num_bits_i;
  logic        rx_i;
  logic        quad_i;
  logic        last_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] rx_data_o;
  logic        sck_o;
  logic        cs_n_o;
  logic [3:0]  io_o;
  logic [3:0]  io_oe_o;
  logic [3:0]  io_i;

  int checks = 0;
  int errors = 0;
  vec_t vecs[9];

  qspi_shift_engine #(.CLK_DIV(CLK_DIV), .CS_IDLE_CYCLES(CS_IDLE_CYCLES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_i(load_i), .data_i(data_i),
    .num_bits_i(num_bits_i), .rx_i(rx_i), .quad_i(quad_i), .last_i(last_i),
    .ready_o(ready_o), .done_o(done_o), .rx_data_o(rx_data_o), .sck_o(sck_o),
    .cs_n_o(cs_n_o), .io_o(io_o), .io_oe_o(io_oe_o), .io_i(io_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // After a last segment: CS_n held for CLK_DIV, then idle gap before ready returns.
  task automatic checkTail(input string tag);
    step();
    checkOutput({tag, " done pulse width"}, 32'(done_o), 32'd0);
    checkOutput({tag, " cs held after done"}, 32'(cs_n_o), 32'd0);
    step();
    checkOutput({tag, " cs released"}, 32'(cs_n_o), 32'd1);
    checkOutput({tag, " oe released"}, 32'(io_oe_o), 32'd0);
    repeat (CS_IDLE_CYCLES - 1) step();
    checkOutput({tag, " ready before gap end"}, 32'(ready_o), 32'd0);
    step();
    checkOutput({tag, " ready after gap"}, 32'(ready_o), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int waitCnt;
    int k;
    int doneAt;
    int rises;
    int laneBad;
    int n;
    int nbc;
    logic [31:0] txCap;
    logic [31:0] rxGot;
    logic        prevSck;
    logic [3:0]  expOe;
    nbc   = (v.nb > 6'd32) ? 32 : int'(v.nb);
    n     = v.quad ? (nbc + 3) / 4 : nbc;
    expOe = v.rx ? (v.quad ? 4'b0000 : 4'b0001) : (v.quad ? 4'b1111 : 4'b0001);
    waitCnt = 0;
    while (!ready_o && waitCnt < 50) begin
      step();
      waitCnt++;
    end
    if (!ready_o) checkOutput({tag, " ready wait"}, 32'd0, 32'd1);
    data_i     = v.data;
    num_bits_i = v.nb;
    rx_i       = v.rx;
    quad_i     = v.quad;
    last_i     = v.last;
    load_i     = 1'b1;
    step();
    load_i  = 1'b0;
    k       = 1;
    doneAt  = -1;
    rises   = 0;
    laneBad = 0;
    txCap   = 32'h0;
    rxGot   = 32'h0;
    prevSck = 1'b0;
    while (doneAt < 0 && k < 400) begin
      if (sck_o && !prevSck) begin
        rises++;
        txCap = v.quad ? {txCap[27:0], io_o} : {txCap[30:0], io_o[0]};
      end
      prevSck = sck_o;
      if (done_o) begin
        doneAt = k;
        rxGot  = rx_data_o;
      end else if (nbc > 0 && (io_oe_o !== expOe || cs_n_o !== 1'b0 || (v.rx && io_o !== 4'b0000))) begin
        laneBad++;
      end
      if (rises < n) begin
        if (v.quad) io_i = 4'((v.rxSrc >> (4 * (n - 1 - rises))) & 32'hF);
        else        io_i = {2'b00, v.rxSrc[n - 1 - rises], 1'b0};
      end else begin
        io_i = 4'b0000;
      end
      if (doneAt < 0) begin
        step();
        k++;
      end
    end
    io_i = 4'b0000;
    checkOutput({tag, " done cycle"}, 32'(doneAt), 32'(v.expDone));
    checkOutput({tag, " sck rises"}, 32'(rises), 32'(v.expRises));
    checkOutput({tag, " sck low at done"}, 32'(sck_o), 32'd0);
    checkOutput({tag, " rx data"}, rxGot, v.expRx);
    checkOutput({tag, " lane/cs errors"}, 32'(laneBad), 32'd0);
    if (!v.rx) checkOutput({tag, " tx bits"}, txCap, v.expTx);
    if (v.last) begin
      checkTail(tag);
    end else begin
      checkOutput({tag, " ready at done"}, 32'(ready_o), 32'd1);
      checkOutput({tag, " cs at done"}, 32'(cs_n_o), (nbc == 0) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int k;
    int doneCount;
    int firstDone;
    int csRiseAt;
    int readyAt;
    int rises;
    logic prevSck;
    logic csWasLow;

    //           rx    quad  nb     data           last  rxSrc          done rises expTx          expRx
    vecs[0] = '{1'b0, 1'b0, 6'd8,  32'h0000_00A5, 1'b1, 32'h0,         33,  8,  32'h0000_00A5, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 6'd32, 32'h0,         1'b1, 32'hDEAD_BEEF, 33,  8,  32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 6'd8,  32'h0000_00EB, 1'b0, 32'h0,         33,  8,  32'h0000_00EB, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 6'd24, 32'h0012_3456, 1'b1, 32'h0,         25,  6,  32'h0012_3456, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 6'd12, 32'h0,         1'b1, 32'hFFFF_FABC, 49,  12, 32'h0,         32'h0000_0ABC};
    vecs[5] = '{1'b0, 1'b1, 6'd6,  32'h0000_FF2D, 1'b1, 32'h0,         9,   2,  32'h0000_002D, 32'h0000_0ABC};
    vecs[6] = '{1'b1, 1'b0, 6'd0,  32'h0,         1'b0, 32'hFFFF_FFFF, 1,   0,  32'h0,         32'h0};
    vecs[7] = '{1'b1, 1'b1, 6'd7,  32'h0,         1'b1, 32'h0000_00DF, 9,   2,  32'h0,         32'h0000_005F};
    vecs[8] = '{1'b0, 1'b0, 6'd40, 32'h8000_0001, 1'b1, 32'h0,         129, 32, 32'h8000_0001, 32'h0000_005F};

    rst_i = 1'b1; load_i = 1'b0; data_i = 32'h0; num_bits_i = 6'd0;
    rx_i = 1'b0; quad_i = 1'b0; last_i = 1'b0; io_i = 4'b0000;
    repeat (3) step();
    rst_i = 1'b0;
    checkOutput("reset ready", 32'(ready_o), 32'd1);
    checkOutput("reset done", 32'(done_o), 32'd0);
    checkOutput("reset rx_data", rx_data_o, 32'h0);
    checkOutput("reset sck", 32'(sck_o), 32'd0);
    checkOutput("reset cs_n", 32'(cs_n_o), 32'd1);
    checkOutput("reset io", 32'(io_o), 32'd0);
    checkOutput("reset io_oe", 32'(io_oe_o), 32'd0);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // load_i held high: the second segment may only start when ready_o returns.
    $display("[TB] held load_i sequence");
    data_i = 32'h9; num_bits_i = 6'd4; rx_i = 1'b0; quad_i = 1'b0; last_i = 1'b1;
    load_i = 1'b1;
    step();
    doneCount = 0; firstDone = -1; csRiseAt = -1; readyAt = -1; csWasLow = 1'b0;
    for (k = 1; k <= 23; k++) begin
      if (done_o) begin
        doneCount++;
        if (firstDone < 0) firstDone = k;
      end
      if (!cs_n_o) csWasLow = 1'b1;
      if (cs_n_o && csWasLow && csRiseAt < 0) csRiseAt = k;
      if (ready_o && readyAt < 0) readyAt = k;
      step();
    end
    checkOutput("held done count", 32'(doneCount), 32'd1);
    checkOutput("held done cycle", 32'(firstDone), 32'd17);
    checkOutput("held cs rise", 32'(csRiseAt), 32'd19);
    checkOutput("held ready return", 32'(readyAt), 32'd23);
    checkOutput("held gap", 32'(readyAt - csRiseAt), 32'(CS_IDLE_CYCLES));
    checkOutput("held second accepted ready", 32'(ready_o), 32'd0);
    checkOutput("held second accepted cs", 32'(cs_n_o), 32'd0);
    load_i = 1'b0;
    k = 0;
    while (!ready_o && k < 100) begin
      step();
      k++;
    end
    checkOutput("held second completes", 32'(ready_o), 32'd1);

    // Reset while the third bit of a segment is on the wire.
    $display("[TB] reset mid-shift sequence");
    data_i = 32'hFF; num_bits_i = 6'd8; rx_i = 1'b0; quad_i = 1'b0; last_i = 1'b1;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    rises = 0; prevSck = 1'b0; k = 0;
    while (rises < 3 && k < 100) begin
      if (sck_o && !prevSck) rises++;
      prevSck = sck_o;
      if (rises < 3) begin
        step();
        k++;
      end
    end
    checkOutput("mid-shift reached bit 3", 32'(rises), 32'd3);
    checkOutput("mid-shift cs low", 32'(cs_n_o), 32'd0);
    rst_i = 1'b1;
    step();
    checkOutput("abort cs_n", 32'(cs_n_o), 32'd1);
    checkOutput("abort sck", 32'(sck_o), 32'd0);
    checkOutput("abort io_oe", 32'(io_oe_o), 32'd0);
    checkOutput("abort ready", 32'(ready_o), 32'd1);
    checkOutput("abort io", 32'(io_o), 32'd0);
    checkOutput("abort rx_data", rx_data_o, 32'h0);
    rst_i = 1'b0;
    step();
    checkOutput("after abort idle cs", 32'(cs_n_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
